// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 candidate generator and
// anything downstream that consumes its blocks.
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam int          CHARSET_BASE = 26;
  localparam logic [7:0]  ASCII_OFFSET = 8'h61;
  localparam int          LEN_MAX      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/md5_pad_block.sv
// Maps an odometer digit vector and a length onto a single padded MD5 block:
// characters, the 0x80 terminator, and the bit length in byte 56.
module md5_pad_block
  import md5_pkg::*;
(
  input  logic [LEN_MAX-1:0][4:0] digits,
  input  logic [3:0]              len,
  output logic [511:0]            block
);

  always_comb begin
    block = '0;
    for (int j = 0; j < LEN_MAX; j++) begin
      if (4'(j) < len) begin
        block[511-8*j -: 8] = ASCII_OFFSET + 8'(digits[j]);
      end
    end
    block[511-8*int'(len) -: 8] = 8'h80;
    // Messages never exceed 8 chars, so the length fits in the low byte.
    block[63:56] = {1'b0, len, 3'b000};
  end

endmodule

// File: rtl/md5_candidate_gen.sv
// Enumerates 'a'..'z' strings from MIN_LEN to MAX_LEN characters as padded
// MD5 blocks, odometer style with the rightmost character fastest.
module md5_candidate_gen
  import md5_pkg::*;
#(
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         hold,
  input  logic         abort,
  output logic [511:0] m,
  output logic [31:0]  a,
  output logic [31:0]  b,
  output logic [31:0]  c,
  output logic [31:0]  d,
  output logic         valid,
  output logic [3:0]   cand_len,
  output logic [47:0]  cand_seq,
  output logic         busy,
  output logic         done,
  output state_t       fsm_state
);

  // valid is a one-cycle strobe with no back-pressure: m, cand_len and
  // cand_seq describe a fresh candidate exactly on cycles where valid is 1;
  // the consumer stalls the source only through hold.

  state_t                  state_q, state_d;
  logic [LEN_MAX-1:0][4:0] dig_q, dig_inc;
  logic [3:0]              len_q;
  logic [47:0]             seq_q;
  logic                    carry, all_max, last;
  logic                    init, emit;
  logic [511:0]            pad_out;

  md5_pad_block u_pad (
    .digits (dig_q),
    .len    (len_q),
    .block  (pad_out)
  );

  // Odometer increment: ripple a carry from the rightmost active digit.
  always_comb begin
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int i = LEN_MAX - 1; i >= 0; i--) begin
      if ((4'(i) < len_q) && carry) begin
        if (dig_q[i] == 5'(CHARSET_BASE - 1)) begin
          dig_inc[i] = 5'd0;
        end else begin
          dig_inc[i] = dig_q[i] + 5'd1;
          carry      = 1'b0;
        end
      end
    end
    all_max = carry;
    last    = carry && (len_q == 4'(MAX_LEN));
  end

  always_comb begin
    state_d = state_q;
    init    = 1'b0;
    emit    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          init    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!hold) begin
          emit = 1'b1;
          if (last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      len_q    <= '0;
      seq_q    <= '0;
      m        <= '0;
      cand_len <= '0;
      cand_seq <= '0;
      valid    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= emit;
      if (init) begin
        dig_q <= '0;
        len_q <= 4'(MIN_LEN);
        seq_q <= '0;
      end else if (emit) begin
        m        <= pad_out;
        cand_len <= len_q;
        cand_seq <= seq_q;
        seq_q    <= seq_q + 48'd1;
        dig_q    <= dig_inc;
        // A full wrap below MAX_LEN rolls into the next length at all zeros.
        if (all_max && !last) len_q <= len_q + 4'd1;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign fsm_state = state_q;
  assign a         = IV_A;
  assign b         = IV_B;
  assign c         = IV_C;
  assign d         = IV_D;

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Directed bench for md5_candidate_gen at MIN_LEN=1, MAX_LEN=2 with a
// scoreboard of expected {len, seq, block} records.
module tb_md5_candidate_gen;
  import md5_pkg::*;

  localparam int NCAND = 26 + 26 * 26;
  localparam int RW    = 4 + 48 + 512;

  logic         clk = 1'b0;
  logic         reset, start, hold, abort;
  logic [511:0] m;
  logic [31:0]  a, b, c, d;
  logic         valid, busy, done;
  logic [3:0]   cand_len;
  logic [47:0]  cand_seq;
  state_t       fsm_state;

  md5_candidate_gen #(.MIN_LEN(1), .MAX_LEN(2)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .m(m), .a(a), .b(b), .c(c), .d(d), .valid(valid),
    .cand_len(cand_len), .cand_seq(cand_seq), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] exp_q[$];
  int n_chk = 0, n_pass = 0, n_valid = 0, cyc = 0, first_v = -1, last_v = -1;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected record for the idx-th candidate of the 1..2 character enumeration.
  function automatic logic [RW-1:0] exp_rec(input int idx);
    logic [511:0] blk;
    int           len;
    int           ch[2];
    blk = '0;
    if (idx < 26) begin
      len = 1; ch[0] = idx; ch[1] = 0;
    end else begin
      len = 2; ch[0] = (idx - 26) / 26; ch[1] = (idx - 26) % 26;
    end
    for (int j = 0; j < len; j++) blk[511-8*j -: 8] = 8'(8'h61 + ch[j]);
    blk[511-8*len -: 8] = 8'h80;
    blk[63:56] = 8'(len * 8);
    return {4'(len), 48'(idx), blk};
  endfunction

  task automatic push_all();
    for (int i = 0; i < NCAND; i++) exp_q.push_back(exp_rec(i));
  endtask

  // One cycle: sample on the falling edge and retire any emitted candidate.
  task automatic tick();
    logic [RW-1:0] e;
    @(negedge clk);
    cyc++;
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", RW'(valid), RW'(0));
      end else begin
        e = exp_q.pop_front();
        chk("cand", {cand_len, cand_seq, m}, e);
        n_valid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
  endtask

  initial begin
    logic [511:0] blk_a;
    reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("rst_valid", RW'(valid), RW'(0));
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    chk("rst_m", RW'(m), RW'(0));
    chk("rst_len", RW'(cand_len), RW'(0));
    chk("rst_seq", RW'(cand_seq), RW'(0));
    chk("iv", RW'({a, b, c, d}), RW'(128'h67452301efcdab8998badcfe10325476));
    reset = 1'b0;
    tick();

    // Full enumeration with latency and first-block checks.
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_valid0", RW'(valid), RW'(0));
    chk("lat_busy", RW'(busy), RW'(1));
    tick();
    chk("lat_valid1", RW'(valid), RW'(1));
    blk_a = '0;
    blk_a[511:504] = 8'h61;
    blk_a[503:496] = 8'h80;
    blk_a[63:56]   = 8'h08;
    chk("first_block", RW'(m), RW'(blk_a));
    for (int t = 0; t < NCAND + 50 && !done; t++) tick();
    chk("n_valid", RW'(n_valid), RW'(NCAND));
    chk("contiguous", RW'(last_v - first_v), RW'(NCAND - 1));
    chk("last_seq", RW'(cand_seq), RW'(NCAND - 1));
    chk("sb_empty", RW'(exp_q.size()), RW'(0));
    tick();
    chk("done_valid", RW'(valid), RW'(0));
    chk("done_flag", RW'(done), RW'(1));
    chk("done_busy", RW'(busy), RW'(0));

    // Restart from DONE, then hold for five cycles after cand_seq 10.
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 50 && !(valid && cand_seq == 48'd10); t++) tick();
    chk("reach_seq10", RW'(cand_seq), RW'(10));
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", RW'(valid), RW'(0));
    end
    hold = 1'b0;
    tick();
    chk("after_hold_valid", RW'(valid), RW'(1));
    chk("after_hold_seq", RW'(cand_seq), RW'(11));

    // Abort at cand_seq 40.
    for (int t = 0; t < 60 && !(valid && cand_seq == 48'd40); t++) tick();
    chk("reach_seq40", RW'(cand_seq), RW'(40));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", RW'(valid), RW'(0));
    chk("abort_busy", RW'(busy), RW'(0));
    chk("abort_state", RW'(fsm_state), RW'(IDLE));
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", RW'(busy), RW'(0));
    tick();
    chk("start_abort_valid", RW'(valid), RW'(0));

    // Restart from IDLE begins at "a", then an asynchronous reset mid-run.
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_seq", RW'(cand_seq), RW'(0));
    chk("restart_char", RW'(m[511:504]), RW'(8'h61));
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_valid", RW'(valid), RW'(0));
    chk("async_busy", RW'(busy), RW'(0));
    chk("async_m", RW'(m), RW'(0));
    chk("async_seq", RW'(cand_seq), RW'(0));
    chk("async_len", RW'(cand_len), RW'(0));
    exp_q.delete();
    tick();
    reset = 1'b0;
    n_valid = 0;
    repeat (10) tick();
    chk("post_reset_nvalid", RW'(n_valid), RW'(0));
    chk("post_reset_state", RW'(fsm_state), RW'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
